// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer: latches two 4-bit operands from a shared async bus, forms
// their 5-bit sum, and on request streams the sum as ASCII hex (optionally
// followed by CR LF) to a byte-wide UART transmitter over a start/busy handshake.
module sum_tx_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          SEND_CRLF   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [3:0] data_input,
  input  logic       uart_tx_en,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [4:0] sum
);

  localparam logic [1:0] LastIdx = SEND_CRLF ? 2'd3 : 2'd1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitAck,
    StWaitDone
  } state_e;

  // Synchronizer chains; index SYNC_STAGES-1 is the synchronized output.
  logic [SYNC_STAGES-1:0] sa_sync_q;
  logic [SYNC_STAGES-1:0] sb_sync_q;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [3:0]             data_sync_q [SYNC_STAGES];

  logic       sa_s, sb_s, en_s;
  logic [3:0] data_s;
  logic       sa_prev_q, sb_prev_q, en_prev_q;
  logic       sa_fall, sb_fall, req_rise;

  logic [3:0] op_a_q, op_b_q;

  state_e     state_q, state_d;
  logic [4:0] msg_q, msg_d;
  logic [1:0] idx_q, idx_d;
  logic       pending_q, pending_d;

  // Data and strobes share identical chains so they stay cycle-aligned.
  // Strobe chains reset to their idle level so reset release creates no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_sync_q <= '1;
      sb_sync_q <= '1;
      en_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= '0;
      end
    end else begin
      sa_sync_q      <= {sa_sync_q[SYNC_STAGES-2:0], save_a_n};
      sb_sync_q      <= {sb_sync_q[SYNC_STAGES-2:0], save_b_n};
      en_sync_q      <= {en_sync_q[SYNC_STAGES-2:0], uart_tx_en};
      data_sync_q[0] <= data_input;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        data_sync_q[i] <= data_sync_q[i-1];
      end
    end
  end

  assign sa_s   = sa_sync_q[SYNC_STAGES-1];
  assign sb_s   = sb_sync_q[SYNC_STAGES-1];
  assign en_s   = en_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Previous-value flops for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_prev_q <= 1'b1;
      sb_prev_q <= 1'b1;
      en_prev_q <= 1'b0;
    end else begin
      sa_prev_q <= sa_s;
      sb_prev_q <= sb_s;
      en_prev_q <= en_s;
    end
  end

  assign sa_fall  = sa_prev_q & ~sa_s;
  assign sb_fall  = sb_prev_q & ~sb_s;
  assign req_rise = en_s & ~en_prev_q;

  // Operand registers load on falling edges of the synchronized save strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      if (sa_fall) op_a_q <= data_s;
      if (sb_fall) op_b_q <= data_s;
    end
  end

  assign op_a = op_a_q;
  assign op_b = op_b_q;
  assign sum  = {1'b0, op_a_q} + {1'b0, op_b_q};

  // FSM state register together with message snapshot, byte index and pending flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      msg_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic; a request seen while busy arms the 1-deep pending flag.
  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    if (req_rise && (state_q != StIdle)) pending_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (req_rise) state_d = StLoad;
      end
      StLoad: begin
        // Operand registers update on this same edge, so sum is still the old value.
        msg_d   = sum;
        idx_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        if (!tx_busy) state_d = StWaitAck;
      end
      StWaitAck: begin
        if (tx_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (idx_q != LastIdx) begin
            idx_d   = idx_q + 2'd1;
            state_d = StSend;
          end else if (pending_q) begin
            // A fresh edge in the consuming cycle re-arms pending.
            pending_d = req_rise;
            state_d   = StLoad;
          end else if (req_rise) begin
            pending_d = 1'b0;
            state_d   = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: start pulse, selected ASCII byte, busy indication.
  always_comb begin
    logic [3:0] lo;
    logic [7:0] byte_sel;
    lo       = msg_q[3:0];
    byte_sel = 8'h00;
    case (idx_q)
      2'd0:    byte_sel = 8'h30 + {7'h00, msg_q[4]};
      2'd1:    byte_sel = (lo < 4'd10) ? (8'h30 + {4'h0, lo}) : (8'h37 + {4'h0, lo});
      2'd2:    byte_sel = 8'h0D;
      default: byte_sel = 8'h0A;
    endcase
    tx_start = (state_q == StSend) && !tx_busy;
    seq_busy = (state_q != StIdle);
    tx_data  = 8'h00;
    if ((state_q == StSend) || (state_q == StWaitAck) || (state_q == StWaitDone)) begin
      tx_data = byte_sel;
    end
  end

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Self-checking bench for sum_tx_sequencer: two instances (with and without
// CR LF), each driving a simple UART model that stays busy 10 cycles per byte.
module tb_sum_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic [3:0] data_input = 4'h0;
  logic       uart_tx_en = 1'b0;
  logic       uart_tx_en2 = 1'b0;

  logic       tx_busy, tx_start, seq_busy;
  logic [7:0] tx_data;
  logic [3:0] op_a, op_b;
  logic [4:0] sum;
  logic       tx_busy2, tx_start2, seq_busy2;
  logic [7:0] tx_data2;
  logic [3:0] op_a2, op_b2;
  logic [4:0] sum2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sum_tx_sequencer #(.SYNC_STAGES(2), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(data_input), .uart_tx_en(uart_tx_en), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .seq_busy(seq_busy),
    .op_a(op_a), .op_b(op_b), .sum(sum)
  );

  sum_tx_sequencer #(.SYNC_STAGES(2), .SEND_CRLF(1'b0)) dut2 (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .data_input(data_input), .uart_tx_en(uart_tx_en2), .tx_busy(tx_busy2),
    .tx_start(tx_start2), .tx_data(tx_data2), .seq_busy(seq_busy2),
    .op_a(op_a2), .op_b(op_b2), .sum(sum2)
  );

  // UART models and byte monitors (not reset: a frame finishes on its own).
  int         cnt1 = 0, pulses1 = 0, viol1 = 0;
  logic       prev1 = 1'b0;
  logic       force1 = 1'b0;
  logic [7:0] rx1_q[$];
  assign tx_busy = (cnt1 != 0) || force1;
  always @(posedge clk) begin
    if (tx_start && (tx_busy || prev1)) viol1 <= viol1 + 1;
    prev1 <= tx_start;
    if (tx_start) begin
      rx1_q.push_back(tx_data);
      pulses1 <= pulses1 + 1;
    end
    if (cnt1 != 0) cnt1 <= cnt1 - 1;
    else if (tx_start) cnt1 <= 10;
  end

  int         cnt2 = 0, pulses2 = 0, viol2 = 0;
  logic       prev2 = 1'b0;
  logic       force2 = 1'b0;
  logic [7:0] rx2_q[$];
  assign tx_busy2 = (cnt2 != 0) || force2;
  always @(posedge clk) begin
    if (tx_start2 && (tx_busy2 || prev2)) viol2 <= viol2 + 1;
    prev2 <= tx_start2;
    if (tx_start2) begin
      rx2_q.push_back(tx_data2);
      pulses2 <= pulses2 + 1;
    end
    if (cnt2 != 0) cnt2 <= cnt2 - 1;
    else if (tx_start2) cnt2 <= 10;
  end

  // Reference: k-th byte of the message for sum value s.
  function automatic logic [7:0] exp_byte(int s, int k);
    int lo;
    lo = s % 16;
    case (k)
      0:       return 8'(48 + s / 16);
      1:       return (lo < 10) ? 8'(48 + lo) : 8'(65 + lo - 10);
      2:       return 8'd13;
      default: return 8'd10;
    endcase
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_a(logic [3:0] v);
    @(negedge clk);
    data_input = v;
    save_a_n = 1'b0;
    cyc(6);
    save_a_n = 1'b1;
    cyc(6);
  endtask

  task automatic load_b(logic [3:0] v);
    @(negedge clk);
    data_input = v;
    save_b_n = 1'b0;
    cyc(6);
    save_b_n = 1'b1;
    cyc(6);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    uart_tx_en = 1'b1;
    cyc(4);
    uart_tx_en = 1'b0;
    cyc(4);
  endtask

  task automatic pulse_req2();
    @(negedge clk);
    uart_tx_en2 = 1'b1;
    cyc(4);
    uart_tx_en2 = 1'b0;
    cyc(4);
  endtask

  task automatic wait_done1(int target, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((pulses1 >= target) && !seq_busy && !tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done2(int target, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((pulses2 >= target) && !seq_busy2 && !tx_busy2) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    cyc(3);
    n_cmp++; if (op_a !== 4'h0) begin n_fail++; $display("FAIL reset_op_a: got %h want 0", op_a); end
    n_cmp++; if (op_b !== 4'h0) begin n_fail++; $display("FAIL reset_op_b: got %h want 0", op_b); end
    n_cmp++; if (sum !== 5'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_seq_busy: got %b want 0", seq_busy); end
    @(negedge clk) reset_n = 1'b1;
    cyc(8);
    n_cmp++; if (seq_busy !== 1'b0 || pulses1 !== 0) begin
      n_fail++; $display("FAIL reset_release: busy %b pulses %0d want 0/0", seq_busy, pulses1);
    end
  endtask

  // One full message for operands a, b checked against the reference bytes.
  task automatic test_message(string name, logic [3:0] a, logic [3:0] b);
    int base, qb, s;
    bit ok;
    load_a(a);
    load_b(b);
    s = int'(a) + int'(b);
    n_cmp++; if (sum !== 5'(s)) begin n_fail++; $display("FAIL %s_sum: got %h want %h", name, sum, 5'(s)); end
    base = pulses1;
    qb = rx1_q.size();
    pulse_req();
    wait_done1(base + 4, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL %s_timeout: got no completion want done", name); end
    n_cmp++; if (pulses1 - base !== 4) begin
      n_fail++; $display("FAIL %s_pulses: got %0d want 4", name, pulses1 - base);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rx1_q[qb + k] !== exp_byte(s, k)) begin
        n_fail++; $display("FAIL %s_byte%0d: got %h want %h", name, k, rx1_q[qb + k], exp_byte(s, k));
      end
    end
    n_cmp++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got %b want 0", name, seq_busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      test_message("random", 4'($urandom_range(15)), 4'($urandom_range(15)));
    end
  endtask

  task automatic test_pending();
    int base, qb;
    bit ok;
    load_a(4'h2);
    load_b(4'h6);
    base = pulses1;
    qb = rx1_q.size();
    pulse_req();
    for (int i = 0; i < 50 && pulses1 < base + 1; i++) @(negedge clk);
    pulse_req();
    pulse_req();
    wait_done1(base + 8, 500, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL pending_timeout: got no completion want done"); end
    cyc(60);
    n_cmp++; if (pulses1 - base !== 8) begin
      n_fail++; $display("FAIL pending_pulses: got %0d want 8", pulses1 - base);
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rx1_q[qb + k] !== exp_byte(8, k % 4)) begin
        n_fail++; $display("FAIL pending_byte%0d: got %h want %h", k, rx1_q[qb + k], exp_byte(8, k % 4));
      end
    end
  endtask

  task automatic test_mid_change();
    int base, qb;
    bit ok;
    load_a(4'h1);
    load_b(4'h2);
    base = pulses1;
    qb = rx1_q.size();
    pulse_req();
    for (int i = 0; i < 60 && pulses1 < base + 2; i++) @(negedge clk);
    load_a(4'h5);
    n_cmp++; if (sum !== 5'h07) begin n_fail++; $display("FAIL midchg_sum: got %h want 07", sum); end
    n_cmp++; if (seq_busy !== 1'b1) begin n_fail++; $display("FAIL midchg_busy: got %b want 1", seq_busy); end
    wait_done1(base + 4, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midchg_timeout1: got no completion want done"); end
    pulse_req();
    wait_done1(base + 8, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midchg_timeout2: got no completion want done"); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (rx1_q[qb + k] !== exp_byte((k < 4) ? 3 : 7, k % 4)) begin
        n_fail++; $display("FAIL midchg_byte%0d: got %h want %h", k, rx1_q[qb + k],
                           exp_byte((k < 4) ? 3 : 7, k % 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, qb, p;
    bit ok;
    load_a(4'h3);
    load_b(4'h4);
    base = pulses1;
    pulse_req();
    for (int i = 0; i < 50 && !(pulses1 >= base + 1 && tx_busy); i++) @(negedge clk);
    cyc(3);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx_data: got %h want 00", tx_data); end
    n_cmp++; if (seq_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_seq_busy: got %b want 0", seq_busy); end
    n_cmp++; if (op_a !== 4'h0 || op_b !== 4'h0 || sum !== 5'h0) begin
      n_fail++; $display("FAIL rstmid_operands: got %h/%h/%h want 0/0/0", op_a, op_b, sum);
    end
    p = pulses1;
    cyc(20);
    @(negedge clk) reset_n = 1'b1;
    cyc(20);
    n_cmp++; if (pulses1 !== p) begin n_fail++; $display("FAIL rstmid_no_resume: got %0d want %0d", pulses1, p); end
    base = pulses1;
    qb = rx1_q.size();
    pulse_req();
    wait_done1(base + 4, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got no completion want done"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rx1_q[qb + k] !== exp_byte(0, k)) begin
        n_fail++; $display("FAIL rstmid_byte%0d: got %h want %h", k, rx1_q[qb + k], exp_byte(0, k));
      end
    end
  endtask

  task automatic test_no_crlf();
    int base, qb;
    bit ok;
    load_a(4'hA);
    load_b(4'h3);
    n_cmp++; if (sum2 !== 5'h0D) begin n_fail++; $display("FAIL nocrlf_sum: got %h want 0d", sum2); end
    base = pulses2;
    qb = rx2_q.size();
    @(negedge clk) force2 = 1'b1;
    pulse_req2();
    cyc(12);
    n_cmp++; if (pulses2 !== base) begin n_fail++; $display("FAIL nocrlf_held: got %0d want %0d", pulses2, base); end
    n_cmp++; if (seq_busy2 !== 1'b1) begin n_fail++; $display("FAIL nocrlf_busy: got %b want 1", seq_busy2); end
    force2 = 1'b0;
    wait_done2(base + 2, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL nocrlf_timeout: got no completion want done"); end
    cyc(40);
    n_cmp++; if (pulses2 - base !== 2) begin
      n_fail++; $display("FAIL nocrlf_pulses: got %0d want 2", pulses2 - base);
    end
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (rx2_q[qb + k] !== exp_byte(13, k)) begin
        n_fail++; $display("FAIL nocrlf_byte%0d: got %h want %h", k, rx2_q[qb + k], exp_byte(13, k));
      end
    end
  endtask

  task automatic test_protocol();
    n_cmp++; if (viol1 !== 0) begin n_fail++; $display("FAIL protocol_dut: got %0d want 0", viol1); end
    n_cmp++; if (viol2 !== 0) begin n_fail++; $display("FAIL protocol_dut2: got %0d want 0", viol2); end
  endtask

  initial begin
    test_reset();
    test_message("basic", 4'h9, 4'h7);
    test_message("max", 4'hF, 4'hF);
    test_random();
    test_pending();
    test_mid_change();
    test_reset_mid();
    test_no_crlf();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_tx_sequencer.md
# sum_tx_sequencer

Controller that sequences the latch-add-transmit datapath. It latches two 4-bit operands from the shared `data_input` bus on the `save_a_n`/`save_b_n` strobes and forms their 5-bit sum. On a `uart_tx_en` request it formats the sum as ASCII hex and feeds the bytes one at a time to the byte-wide UART transmitter over a start/busy handshake. It sits between the pad-level controls and the UART TX, replacing ad-hoc glue in the top level.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on all asynchronous inputs (≥2).
- `SEND_CRLF`, default 1: 1 sends 4-byte message (hi digit, lo digit, 0x0D, 0x0A); 0 sends 2 bytes (digits only).

- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `save_a_n` in 1: async, active-low; falling edge latches operand A.
- `save_b_n` in 1: async, active-low; falling edge latches operand B.
- `data_input` in 4: async operand bus.
- `uart_tx_en` in 1: async; rising edge requests one message.
- `tx_busy` in 1: UART TX busy, synchronous to `clk`.
- `tx_start` out 1: one-cycle byte-start pulse to UART.
- `tx_data` out 8: byte to UART; stable from `tx_start` until byte completes.
- `seq_busy` out 1: high from LOAD until last byte completes.
- `op_a`, `op_b` out 4: latched operands.
- `sum` out 5: `op_a + op_b`, combinational from operand registers, zero-extended, no overflow (max 0x1E).

## Operation
- All four async inputs, including `data_input`, pass through identical `SYNC_STAGES` flop chains so data and strobes stay aligned. `save_*_n` chains reset to 1 and `uart_tx_en` resets to 0, so release of reset creates no edge.
- A registered previous-value flop performs edge detection. Falling edge of synced `save_a_n` loads `op_a` from synced data; same for B. A and B edges in the same cycle both load the same value.
- FSM states:
  - IDLE: on request edge → LOAD.
  - LOAD: snapshot `sum` into a message register, set byte index to 0 → SEND.
  - SEND: when `tx_busy`=0, drive `tx_data` = byte[idx] and pulse `tx_start` → WAIT_ACK. If `tx_busy`=1, hold in SEND with no pulse.
  - WAIT_ACK: wait for `tx_busy`=1 → WAIT_DONE.
  - WAIT_DONE: wait for `tx_busy`=0. If not the last byte, idx+1 → SEND. If last byte, go to LOAD when a request is pending (clear pending), otherwise IDLE.
- Encoding: hi digit = 0x30 + `sum[4]`. Lo nibble n maps to 0x30+n for n<10, else 0x41+(n−10), uppercase.
- Pending request: a request edge while not in IDLE sets a 1-deep pending flag. Further edges while pending is set are dropped.
- Operands may change mid-message. The transmitted message keeps the LOAD snapshot; `op_a`/`op_b`/`sum` outputs update immediately.
- An operand edge in the same cycle as LOAD: the snapshot uses the old operand values, and the new value is visible the next cycle.
- Reset values: `op_a`=0, `op_b`=0, `sum`=0, `tx_start`=0, `tx_data`=0x00, `seq_busy`=0, FSM=IDLE, pending=0, idx=0.
- Reset asserted mid-message: all outputs go to reset values immediately, asynchronously. The UART may finish its current frame on its own, and the sequencer does not resume.

## Timing
- Pin edge to internal strobe: `SYNC_STAGES`+1 cycles (3 by default). Operand registers update on the following edge.
- Request strobe (cycle N) → LOAD at N+1 → `tx_start` at N+2 if `tx_busy`=0.
- Inter-byte gap: `tx_start` for the next byte occurs 1 cycle after `tx_busy` falls (WAIT_DONE→SEND→pulse).
- `tx_start` is never high for 2 consecutive cycles, and never high while `tx_busy`=1.
- `seq_busy` rises in LOAD and falls in the cycle after the final `tx_busy` fall, unless a pending request restarts LOAD directly.

## Test plan
- 9 on `data_input`, `save_a_n` pulse; 7, `save_b_n` pulse; `uart_tx_en` pulse, UART model busy 10 cycles/byte → `sum`=0x10, bytes 0x31, 0x30, 0x0D, 0x0A, 4 `tx_start` pulses, then `seq_busy`=0.
- A=0xF, B=0xF → `sum`=0x1E, bytes 0x31, 0x45, 0x0D, 0x0A.
- Two extra request edges during the first message → exactly one additional message (8 bytes total), and the third request is dropped.
- Change A from 1 to 5 during byte 2 of a message with B=2 → current message "03", `sum` output shows 0x07 immediately, next message "07".
- Assert `reset_n` during WAIT_DONE of byte 1 → `tx_start`/`tx_data`/`seq_busy`/operands are 0 immediately with no further pulses; after release, a new request sends "00\r\n".
- `SEND_CRLF`=0 with `tx_busy` held high for 20 cycles at request → no `tx_start` until `tx_busy` falls, then exactly 2 bytes.
